// File: rtl/udma_filter_bincu_ctrl_pkg.sv
// Shared types for the bincu run sequencer: FSM state encoding and its width.
package udma_filter_bincu_ctrl_pkg;

    localparam int BINCU_STATE_W = 2;

    typedef enum logic [BINCU_STATE_W-1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } bincu_ctrl_state_e;

endpackage

// File: rtl/udma_filter_bincu_ctrl_if.sv
// Sequencer <-> bincu/sample-stream link: start command, activity event, gated valid/ready stream.
interface udma_filter_bincu_ctrl_if;

    logic bincu_cmd_start;
    logic bincu_act_event;
    logic stream_gate;
    logic stream_valid;
    logic stream_ready;
    logic stream_eof;

    modport master (
        output bincu_cmd_start,
        output stream_gate,
        input  bincu_act_event,
        input  stream_valid,
        input  stream_ready,
        input  stream_eof
    );

    modport slave (
        input  bincu_cmd_start,
        input  stream_gate,
        output bincu_act_event,
        output stream_valid,
        output stream_ready,
        output stream_eof
    );

endinterface

// File: rtl/udma_filter_bincu_ctrl.sv
// Run sequencer for the bincu: arms the unit, gates the stream, counts beats, raises done/abort/activity events.
// Events are registered one cycle after their cause; beats only count on valid & ready while running.
module udma_filter_bincu_ctrl
    import udma_filter_bincu_ctrl_pkg::*;
#(
    parameter int TRANS_SIZE = 16,
    parameter bit EVT_PULSE  = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    resetn_i,

    input  logic                    cfg_start_i,
    input  logic                    cfg_stop_i,
    input  logic [TRANS_SIZE-1:0]   cfg_len_i,
    input  logic                    cfg_continuous_i,
    input  logic                    cfg_act_irq_en_i,

    udma_filter_bincu_ctrl_if.master bincu,

    output logic                    busy_o,
    output logic [TRANS_SIZE-1:0]   beat_cnt_o,
    output logic                    done_evt_o,
    output logic                    abort_evt_o,
    output logic                    act_evt_o
);

    bincu_ctrl_state_e state_q, state_d;

    logic [TRANS_SIZE-1:0] r_len;
    logic [TRANS_SIZE-1:0] beat_cnt_q;
    logic                  act_seen_q;
    logic                  cmd_start_q;
    logic                  done_q;
    logic                  abort_q;
    logic                  act_q;

    logic beat;
    logic last_beat;
    logic stop_eff;
    logic accept_start;
    logic rearm;
    logic act_fire;
    logic evt_clr;

    assign beat         = bincu.stream_valid & bincu.stream_ready & (state_q == RUN);
    assign last_beat    = beat & (bincu.stream_eof | (beat_cnt_q == r_len - TRANS_SIZE'(1)));
    assign stop_eff     = cfg_stop_i & (state_q != IDLE);
    assign accept_start = (state_q == IDLE) & cfg_start_i & ~cfg_stop_i & (cfg_len_i != '0);
    assign rearm        = (state_q == DONE) & ~cfg_stop_i & cfg_continuous_i;
    // ARM is the cmd_start cycle, so only RUN/DONE may raise the activity event
    assign act_fire     = ((state_q == RUN) | (state_q == DONE)) & bincu.bincu_act_event
                          & cfg_act_irq_en_i & ~act_seen_q;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept_start) state_d = ARM;
            ARM:  state_d = cfg_stop_i ? IDLE : RUN;
            RUN: begin
                if (cfg_stop_i)     state_d = IDLE;
                else if (last_beat) state_d = DONE;
            end
            DONE: state_d = rearm ? ARM : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bincu.stream_gate = (state_q == RUN);
        busy_o            = (state_q != IDLE);
        evt_clr           = accept_start | rearm;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cmd_start_q <= 1'b0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            act_q       <= 1'b0;
        end else begin
            cmd_start_q <= (state_d == ARM);
            if (EVT_PULSE) begin
                done_q  <= (state_d == DONE);
                abort_q <= stop_eff;
                act_q   <= act_fire;
            end else begin
                done_q  <= (state_d == DONE) | (done_q  & ~evt_clr);
                abort_q <= stop_eff          | (abort_q & ~evt_clr);
                act_q   <= act_fire          | (act_q   & ~evt_clr);
            end
        end
    end

    // A stop in the same cycle as a beat leaves the count untouched
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_len      <= '0;
            beat_cnt_q <= '0;
            act_seen_q <= 1'b0;
        end else begin
            if (accept_start) begin
                r_len      <= cfg_len_i;
                beat_cnt_q <= '0;
            end else if (rearm) begin
                beat_cnt_q <= '0;
            end else if (beat & ~cfg_stop_i) begin
                beat_cnt_q <= beat_cnt_q + TRANS_SIZE'(1);
            end

            if (evt_clr) begin
                act_seen_q <= 1'b0;
            end else if (act_fire) begin
                act_seen_q <= 1'b1;
            end
        end
    end

    assign bincu.bincu_cmd_start = cmd_start_q;
    assign beat_cnt_o            = beat_cnt_q;
    assign done_evt_o            = done_q;
    assign abort_evt_o           = abort_q;
    assign act_evt_o             = act_q;

endmodule

// File: tb/tb_udma_filter_bincu_ctrl.sv
// Self-checking bench for the bincu run sequencer: reference model plus directed and random runs.
module tb_udma_filter_bincu_ctrl;

    localparam int TS = 16;

    logic          clk_i    = 1'b0;
    logic          resetn_i = 1'b0;
    logic          cfg_start_i, cfg_stop_i, cfg_continuous_i, cfg_act_irq_en_i;
    logic [TS-1:0] cfg_len_i;
    logic          busy_o, done_evt_o, abort_evt_o, act_evt_o;
    logic [TS-1:0] beat_cnt_o;

    udma_filter_bincu_ctrl_if bif ();

    udma_filter_bincu_ctrl #(.TRANS_SIZE(TS), .EVT_PULSE(1'b1)) dut (
        .clk_i            (clk_i),
        .resetn_i         (resetn_i),
        .cfg_start_i      (cfg_start_i),
        .cfg_stop_i       (cfg_stop_i),
        .cfg_len_i        (cfg_len_i),
        .cfg_continuous_i (cfg_continuous_i),
        .cfg_act_irq_en_i (cfg_act_irq_en_i),
        .bincu            (bif),
        .busy_o           (busy_o),
        .beat_cnt_o       (beat_cnt_o),
        .done_evt_o       (done_evt_o),
        .abort_evt_o      (abort_evt_o),
        .act_evt_o        (act_evt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cmd, n_gate, n_done, n_abort, n_act;

    // Reference model: run phase, length, accepted beats, activity already reported
    typedef enum {M_IDLE, M_ARM, M_RUN, M_DONE} mph_t;
    mph_t        ph;
    int unsigned m_len, m_cnt;
    bit          m_act_seen;
    bit          e_cmd, e_gate, e_busy, e_done, e_abort, e_act;
    int unsigned e_cnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = M_IDLE; m_len = 0; m_cnt = 0; m_act_seen = 0;
        e_cmd = 0; e_gate = 0; e_busy = 0; e_done = 0; e_abort = 0; e_act = 0; e_cnt = 0;
    endtask

    // Predict outputs after the coming clock edge from the inputs currently applied
    task automatic model_step();
        bit beat, stop_eff, fire;
        beat     = bif.stream_valid && bif.stream_ready && ph == M_RUN;
        stop_eff = cfg_stop_i && ph != M_IDLE;
        fire     = (ph == M_RUN || ph == M_DONE) && bif.bincu_act_event
                   && cfg_act_irq_en_i && !m_act_seen;
        e_abort  = stop_eff;
        e_act    = fire;
        if (fire) m_act_seen = 1;
        case (ph)
            M_IDLE: if (cfg_start_i && !cfg_stop_i && cfg_len_i != 0) begin
                m_len = cfg_len_i; m_cnt = 0; m_act_seen = 0; ph = M_ARM;
            end
            M_ARM: ph = cfg_stop_i ? M_IDLE : M_RUN;
            M_RUN: begin
                if (cfg_stop_i) ph = M_IDLE;
                else if (beat) begin
                    m_cnt++;
                    if (bif.stream_eof || m_cnt == m_len) ph = M_DONE;
                end
            end
            M_DONE: begin
                if (!cfg_stop_i && cfg_continuous_i) begin
                    m_cnt = 0; m_act_seen = 0; ph = M_ARM;
                end else ph = M_IDLE;
            end
        endcase
        e_cmd  = (ph == M_ARM);
        e_gate = (ph == M_RUN);
        e_busy = (ph != M_IDLE);
        e_done = (ph == M_DONE);
        e_cnt  = m_cnt;
    endtask

    task automatic check_outputs();
        check("cmd_start", 32'(bif.bincu_cmd_start), 32'(e_cmd));
        check("gate",      32'(bif.stream_gate),     32'(e_gate));
        check("busy",      32'(busy_o),              32'(e_busy));
        check("beat_cnt",  32'(beat_cnt_o),          e_cnt);
        check("done_evt",  32'(done_evt_o),          32'(e_done));
        check("abort_evt", 32'(abort_evt_o),         32'(e_abort));
        check("act_evt",   32'(act_evt_o),           32'(e_act));
        n_cmd   += int'(bif.bincu_cmd_start === 1'b1);
        n_gate  += int'(bif.stream_gate === 1'b1);
        n_done  += int'(done_evt_o === 1'b1);
        n_abort += int'(abort_evt_o === 1'b1);
        n_act   += int'(act_evt_o === 1'b1);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic clr_counts();
        n_cmd = 0; n_gate = 0; n_done = 0; n_abort = 0; n_act = 0;
    endtask

    task automatic quiet_inputs();
        cfg_start_i = 0; cfg_stop_i = 0; cfg_len_i = '0; cfg_continuous_i = 0;
        cfg_act_irq_en_i = 0;
        bif.bincu_act_event = 0; bif.stream_valid = 0; bif.stream_ready = 0; bif.stream_eof = 0;
    endtask

    task automatic start_run(input int len);
        cfg_len_i = TS'(len); cfg_start_i = 1;
        tick();
        cfg_start_i = 0; cfg_len_i = '0;
    endtask

    initial begin
        quiet_inputs();
        model_reset();
        clr_counts();
        @(negedge clk_i);
        check_outputs();
        resetn_i = 1;
        repeat (2) tick();

        // Length-terminated run
        clr_counts();
        bif.stream_valid = 1; bif.stream_ready = 1;
        start_run(4);
        repeat (7) tick();
        check("len4_cmd_count",  32'(n_cmd),  32'd1);
        check("len4_gate_count", 32'(n_gate), 32'd4);
        check("len4_done_count", 32'(n_done), 32'd1);
        check("len4_beat_cnt",   32'(beat_cnt_o), 32'd4);
        check("len4_busy_after", 32'(busy_o), 32'd0);

        // EOF ends the run on the third beat
        clr_counts();
        start_run(10);
        repeat (3) tick();
        bif.stream_eof = 1;
        tick();
        bif.stream_eof = 0;
        repeat (3) tick();
        check("eof_beat_cnt",    32'(beat_cnt_o), 32'd3);
        check("eof_done_count",  32'(n_done),  32'd1);
        check("eof_abort_count", 32'(n_abort), 32'd0);

        // Backpressure: valid held high, ready alternating; IDLE beats ignored
        clr_counts();
        bif.stream_valid = 1; bif.stream_ready = 1;
        repeat (2) tick();
        start_run(3);
        for (int i = 0; i < 12; i++) begin
            bif.stream_ready = i[0];
            tick();
        end
        bif.stream_ready = 1;
        check("bp_beat_cnt",   32'(beat_cnt_o), 32'd3);
        check("bp_done_count", 32'(n_done), 32'd1);

        // Activity event: one report per run even with several pulses
        clr_counts();
        cfg_act_irq_en_i = 1;
        bif.stream_valid = 0;
        start_run(8);
        bif.bincu_act_event = 1; tick();
        bif.bincu_act_event = 0; tick();
        bif.bincu_act_event = 1; tick();
        bif.bincu_act_event = 0; repeat (2) tick();
        bif.bincu_act_event = 1; tick();
        bif.bincu_act_event = 0;
        bif.stream_valid = 1;
        repeat (10) tick();
        check("act_en_count", 32'(n_act), 32'd1);
        clr_counts();
        cfg_act_irq_en_i = 0;
        start_run(3);
        bif.bincu_act_event = 1;
        repeat (6) tick();
        bif.bincu_act_event = 0;
        check("act_dis_count", 32'(n_act), 32'd0);

        // Stop on the final beat beats completion
        clr_counts();
        start_run(4);
        repeat (4) tick();
        cfg_stop_i = 1; tick();
        cfg_stop_i = 0;
        check("abort_evt_now",  32'(abort_evt_o), 32'd1);
        check("abort_busy_now", 32'(busy_o), 32'd0);
        repeat (2) tick();
        check("abort_count",    32'(n_abort), 32'd1);
        check("abort_no_done",  32'(n_done), 32'd0);
        check("abort_beat_cnt", 32'(beat_cnt_o), 32'd3);
        clr_counts();
        start_run(0);
        repeat (3) tick();
        check("len0_cmd_count", 32'(n_cmd), 32'd0);
        check("len0_busy",      32'(busy_o), 32'd0);

        // Continuous: three runs of two beats, rearm dropped during the third
        clr_counts();
        cfg_continuous_i = 1;
        start_run(2);
        for (int i = 0; i < 15; i++) begin
            if (i == 8) cfg_continuous_i = 0;
            tick();
        end
        check("cont_cmd_count",  32'(n_cmd),  32'd3);
        check("cont_done_count", 32'(n_done), 32'd3);
        check("cont_busy_after", 32'(busy_o), 32'd0);

        // Asynchronous reset in the middle of a run
        start_run(6);
        repeat (3) tick();
        #2 resetn_i = 0;
        #1;
        model_reset();
        check("arst_busy",     32'(busy_o), 32'd0);
        check("arst_cmd",      32'(bif.bincu_cmd_start), 32'd0);
        check("arst_beat_cnt", 32'(beat_cnt_o), 32'd0);
        check("arst_gate",     32'(bif.stream_gate), 32'd0);
        @(negedge clk_i);
        check_outputs();
        resetn_i = 1;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cfg_start_i         = ($urandom_range(0, 7) == 0);
            cfg_stop_i          = ($urandom_range(0, 24) == 0);
            cfg_len_i           = ($urandom_range(0, 9) == 0) ? TS'(0) : TS'($urandom_range(1, 6));
            if ($urandom_range(0, 15) == 0) cfg_continuous_i = ~cfg_continuous_i;
            if ($urandom_range(0, 31) == 0) cfg_act_irq_en_i = ~cfg_act_irq_en_i;
            bif.bincu_act_event = ($urandom_range(0, 3) == 0);
            bif.stream_valid    = ($urandom_range(0, 3) != 0);
            bif.stream_ready    = ($urandom_range(0, 2) != 0);
            bif.stream_eof      = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
